scene_animator: RTL

Frame-synchronous animation controller that produces the three rotation angles and the active model index consumed by the per-vertex rotation engines and scene-object ROM. It generalises the fixed free-running angle/model timer to a configurable number of models, dwell time, and per-axis step, and adds user control from the 8-bit `ui_in` bus: pause, reverse, speed, auto/manual cycling, next-model button and angle reset. All state advances only on the VGA `frame` pulse, so geometry never changes mid-frame.

---
 rtl/scene_animator.sv | 90 +++++++++
 1 files changed

// File: rtl/scene_animator.sv
// scene_animator: frame-synchronous rotation angle and model index sequencer with ui_in control
module scene_animator #(
    parameter int NUM_MODELS   = 4,
    parameter int MODEL_W      = $clog2(NUM_MODELS),
    parameter int ANGLE_W      = 16,
    parameter int DWELL_FRAMES = 180,
    parameter int DWELL_W      = $clog2(DWELL_FRAMES) + 1,
    parameter int STEP_X       = 7,
    parameter int STEP_Y       = 7,
    parameter int STEP_Z       = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame,
    input  logic [7:0]                ctrl,
    output logic signed [ANGLE_W-1:0] angle_x,
    output logic signed [ANGLE_W-1:0] angle_y,
    output logic signed [ANGLE_W-1:0] angle_z,
    output logic [MODEL_W-1:0]        model_select,
    output logic                      model_changed,
    output logic [DWELL_W-1:0]        dwell_count
);
    logic [7:0]         ctrl_q;
    logic               btn_prev;
    logic               pending;
    logic               btn_edge;
    logic               next_req;
    logic               auto_adv;
    logic               advance;
    logic               unused_ctrl;
    logic [ANGLE_W-1:0] step_x;
    logic [ANGLE_W-1:0] step_y;
    logic [ANGLE_W-1:0] step_z;

    assign unused_ctrl = ctrl_q[6];
    assign btn_edge    = ctrl_q[5] & ~btn_prev;
    assign next_req    = pending | btn_edge;
    assign auto_adv    = ctrl_q[4] & ~ctrl_q[0] & (dwell_count == DWELL_W'(DWELL_FRAMES - 1));
    assign advance     = next_req | auto_adv;
    assign step_x      = ANGLE_W'(STEP_X) << ctrl_q[3:2];
    assign step_y      = ANGLE_W'(STEP_Y) << ctrl_q[3:2];
    assign step_z      = ANGLE_W'(STEP_Z) << ctrl_q[3:2];

    // Input capture; the button history is primed during reset so a held button gives no edge
    always_ff @(posedge clk) begin
        ctrl_q   <= ctrl;
        btn_prev <= rst ? ctrl[5] : ctrl_q[5];
        pending  <= rst || frame ? 1'b0 : pending | btn_edge;
    end

    // Angle integration: reset-to-zero beats pause, pause beats direction
    always_ff @(posedge clk) begin
        if (rst) begin
            angle_x <= '0;
            angle_y <= '0;
            angle_z <= '0;
        end else if (frame) begin
            if (ctrl_q[7]) begin
                angle_x <= '0;
                angle_y <= '0;
                angle_z <= '0;
            end else if (!ctrl_q[0]) begin
                angle_x <= ctrl_q[1] ? angle_x - step_x : angle_x + step_x;
                angle_y <= ctrl_q[1] ? angle_y - step_y : angle_y + step_y;
                angle_z <= ctrl_q[1] ? angle_z - step_z : angle_z + step_z;
            end
        end
    end

    // Model sequencing and dwell timing; a manual and an automatic request together still step once
    always_ff @(posedge clk) begin
        if (rst) begin
            model_select  <= '0;
            dwell_count   <= '0;
            model_changed <= 1'b0;
        end else begin
            model_changed <= frame & advance;
            if (frame) begin
                if (advance) begin
                    model_select <= model_select == MODEL_W'(NUM_MODELS - 1) ? '0 : model_select + MODEL_W'(1);
                    dwell_count  <= '0;
                end else if (!ctrl_q[4]) begin
                    dwell_count  <= '0;
                end else if (!ctrl_q[0]) begin
                    dwell_count  <= dwell_count + DWELL_W'(1);
                end
            end
        end
    end
endmodule
